// File: rtl/fetch_redirect_if.sv
// Fetch/redirect bundle between the backend (master) and the fetch redirect controller (slave).
// The master drives stall, memory-ready and redirect requests; the slave drives the fetch pair and status.
interface fetch_redirect_if;
    logic        stall;
    logic        mem_ready;
    logic        branch_req;
    logic        jalr_req;
    logic        jump_req;
    logic [31:0] branch_pc;
    logic [31:0] jalr_pc;
    logic [31:0] jump_pc;
    logic [31:0] pc_0;
    logic [31:0] pc_1;
    logic [1:0]  pc_source;
    logic        fetch_valid;
    logic        flush;
    logic        redirect_pending;
    logic [31:0] redirect_count;

    modport master (
        output stall, mem_ready, branch_req, jalr_req, jump_req,
               branch_pc, jalr_pc, jump_pc,
        input  pc_0, pc_1, pc_source, fetch_valid, flush,
               redirect_pending, redirect_count
    );

    modport slave (
        input  stall, mem_ready, branch_req, jalr_req, jump_req,
               branch_pc, jalr_pc, jump_pc,
        output pc_0, pc_1, pc_source, fetch_valid, flush,
               redirect_pending, redirect_count
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Dual-slot fetch PC sequencer with branch/jalr/jump redirect, stall-time redirect latch and flush pulse.
// Optional macro REDIRECT_CNT_EN enables a saturating count of flush pulses on redirect_count.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_redirect_if.slave   bus
);
    typedef enum logic [1:0] {BOOT, RUN, STALL, BUBBLE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_0_reg, pc_0_next;
    logic [31:0] pc_1_reg;
    logic        fetch_valid_reg;
    logic        flush_reg, flush_next;
    logic        pending_reg, pending_next;
    logic [31:0] latch_target_reg, latch_target_next;

    logic        any_req;
    logic [1:0]  win_src;
    logic [31:0] win_target;

    // Same-cycle arbitration: branch beats jalr beats jump; targets are word aligned.
    always_comb begin
        win_src    = 2'd0;
        win_target = 32'h0;
        if (bus.branch_req) begin
            win_src    = 2'd2;
            win_target = bus.branch_pc & ~32'h3;
        end else if (bus.jalr_req) begin
            win_src    = 2'd1;
            win_target = bus.jalr_pc & ~32'h3;
        end else if (bus.jump_req) begin
            win_src    = 2'd3;
            win_target = bus.jump_pc & ~32'h3;
        end
    end

    assign any_req = bus.branch_req | bus.jalr_req | bus.jump_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= BOOT;
            pc_0_reg         <= RESET_VEC;
            pc_1_reg         <= RESET_VEC + 32'd4;
            fetch_valid_reg  <= 1'b0;
            flush_reg        <= 1'b0;
            pending_reg      <= 1'b0;
            latch_target_reg <= 32'h0;
        end else begin
            state_reg        <= state_next;
            pc_0_reg         <= pc_0_next;
            pc_1_reg         <= pc_0_next + 32'd4;
            fetch_valid_reg  <= (state_next == RUN);
            flush_reg        <= flush_next;
            pending_reg      <= pending_next;
            latch_target_reg <= latch_target_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BOOT:    state_next = RUN;
            RUN:     state_next = any_req ? BUBBLE : (bus.stall ? STALL : RUN);
            STALL: begin
                if (!bus.stall)
                    state_next = (any_req || pending_reg) ? BUBBLE : RUN;
            end
            BUBBLE:  state_next = any_req ? BUBBLE : (bus.stall ? STALL : RUN);
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        pc_0_next         = pc_0_reg;
        flush_next        = 1'b0;
        pending_next      = pending_reg;
        latch_target_next = latch_target_reg;
        case (state_reg)
            RUN: begin
                if (any_req) begin
                    pc_0_next  = win_target;
                    flush_next = 1'b1;
                end else if (!bus.stall && bus.mem_ready) begin
                    pc_0_next = pc_0_reg + 32'd8;
                end
            end
            STALL: begin
                if (!bus.stall) begin
                    // A request arriving with the stall release supersedes the latched one.
                    if (any_req) begin
                        pc_0_next  = win_target;
                        flush_next = 1'b1;
                    end else if (pending_reg) begin
                        pc_0_next  = latch_target_reg;
                        flush_next = 1'b1;
                    end
                    pending_next      = 1'b0;
                    latch_target_next = 32'h0;
                end else if (any_req && (!pending_reg || bus.branch_req || bus.jalr_req)) begin
                    latch_target_next = win_target;
                    pending_next      = 1'b1;
                end
            end
            BUBBLE: begin
                if (any_req) begin
                    pc_0_next  = win_target;
                    flush_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef REDIRECT_CNT_EN
    logic [31:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_reg <= 32'h0;
        else if (flush_next && (count_reg != 32'hFFFF_FFFF))
            count_reg <= count_reg + 32'd1;
    end

    assign bus.redirect_count = count_reg;
`else
    assign bus.redirect_count = 32'h0;
`endif

    assign bus.pc_0             = pc_0_reg;
    assign bus.pc_1             = pc_1_reg;
    assign bus.pc_source        = win_src;
    assign bus.fetch_valid      = fetch_valid_reg;
    assign bus.flush            = flush_reg;
    assign bus.redirect_pending = pending_reg;
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_fetch_redirect_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fetch_redirect_if bus();

    fetch_redirect_ctrl #(.RESET_VEC(32'h0000_0100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam int F_PC0 = 0, F_PC1 = 1, F_SRC = 2, F_FV = 3, F_FLUSH = 4, F_PEND = 5, F_CNT = 6;

    typedef struct {
        int          cyc;
        int          field;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passed = 0;
    int   nred   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pick(int f);
        case (f)
            F_PC0:   return bus.pc_0;
            F_PC1:   return bus.pc_1;
            F_SRC:   return {30'h0, bus.pc_source};
            F_FV:    return {31'h0, bus.fetch_valid};
            F_FLUSH: return {31'h0, bus.flush};
            F_PEND:  return {31'h0, bus.redirect_pending};
            default: return bus.redirect_count;
        endcase
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
            $display("ok   %s = 0x%08h", name, act);
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic int exp_cnt(int n);
`ifdef REDIRECT_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    // Monitor: consume every expectation scheduled for the current cycle.
    always @(negedge clk) begin
        exp_t keep[$];
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc)
                chk(sb[i].name, pick(sb[i].field), sb[i].val);
            else if (sb[i].cyc < cyc) begin
                checks++;
                $display("FAIL %s: expectation for cycle %0d never sampled", sb[i].name, sb[i].cyc);
            end else
                keep.push_back(sb[i]);
        end
        sb = keep;
    end

    task automatic exp_at(int off, int f, logic [31:0] v, string n);
        exp_t e;
        e.cyc = cyc + off; e.field = f; e.val = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_req();
        bus.branch_req = 1'b0;
        bus.jalr_req   = 1'b0;
        bus.jump_req   = 1'b0;
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_pc0"},   bus.pc_0,             32'h100);
        chk({tag, "_pc1"},   bus.pc_1,             32'h104);
        chk({tag, "_fv"},    {31'h0, bus.fetch_valid},      32'h0);
        chk({tag, "_flush"}, {31'h0, bus.flush},            32'h0);
        chk({tag, "_pend"},  {31'h0, bus.redirect_pending}, 32'h0);
        chk({tag, "_cnt"},   bus.redirect_count,   32'h0);
    endtask

    initial begin
        bus.stall = 1'b0; bus.mem_ready = 1'b1;
        clr_req();
        bus.branch_pc = 32'h0; bus.jalr_pc = 32'h0; bus.jump_pc = 32'h0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        step(2);

        // Reset release: one BOOT cycle, then sequential fetch by 8.
        rst_n = 1'b1;
        exp_at(0, F_FV, 0, "boot_fv");
        exp_at(1, F_FV, 1, "run_fv");
        exp_at(1, F_PC0, 32'h100, "seq_pc0_a");
        exp_at(2, F_PC0, 32'h108, "seq_pc0_b");
        exp_at(3, F_PC0, 32'h110, "seq_pc0_c");
        exp_at(3, F_PC1, 32'h114, "seq_pc1_c");
        step(3);

        // Branch and jump together: branch wins, two-cycle latency.
        bus.branch_req = 1'b1; bus.branch_pc = 32'h2000;
        bus.jump_req   = 1'b1; bus.jump_pc   = 32'h3000;
        exp_at(0, F_SRC, 2, "prio_src");
        exp_at(1, F_FLUSH, 1, "prio_flush");
        exp_at(1, F_FV, 0, "prio_bubble_fv");
        exp_at(1, F_PC0, 32'h2000, "prio_pc0_n1");
        exp_at(2, F_FV, 1, "prio_fv_n2");
        exp_at(2, F_PC0, 32'h2000, "prio_pc0_n2");
        exp_at(2, F_FLUSH, 0, "prio_flush_n2");
        nred++;
        step(); clr_req();
        step();

        // mem_ready low holds the PC, then it advances again.
        bus.mem_ready = 1'b0;
        exp_at(0, F_SRC, 0, "idle_src");
        exp_at(1, F_PC0, 32'h2000, "hold_pc0");
        step();
        bus.mem_ready = 1'b1;
        exp_at(1, F_PC0, 32'h2008, "adv_pc0");
        step();

        // Stall with jalr then jump: jump ignored, jalr target taken on release.
        bus.stall = 1'b1;
        exp_at(1, F_FV, 0, "stall_fv");
        exp_at(1, F_PC0, 32'h2008, "stall_pc0");
        step();
        bus.jalr_req = 1'b1; bus.jalr_pc = 32'h4003;
        exp_at(0, F_SRC, 1, "jalr_src");
        exp_at(1, F_PEND, 1, "pend_a");
        step(); clr_req();
        bus.jump_req = 1'b1; bus.jump_pc = 32'h5000;
        exp_at(0, F_SRC, 3, "jump_src");
        exp_at(1, F_PEND, 1, "pend_b");
        step(); clr_req();
        exp_at(1, F_PEND, 1, "pend_c");
        step();
        bus.stall = 1'b0;
        exp_at(1, F_FLUSH, 1, "rel_flush");
        exp_at(1, F_PEND, 0, "rel_pend");
        exp_at(1, F_PC0, 32'h4000, "rel_pc0");
        exp_at(2, F_FV, 1, "rel_fv");
        exp_at(2, F_PC0, 32'h4000, "rel_pc0_run");
        nred++;
        step(2);
        exp_at(0, F_CNT, exp_cnt(nred), "cnt_a");

        // Later branch overwrites a latched jump.
        bus.stall = 1'b1;
        step();
        bus.jump_req = 1'b1; bus.jump_pc = 32'h6000;
        step(); clr_req();
        bus.branch_req = 1'b1; bus.branch_pc = 32'h7000;
        exp_at(1, F_PEND, 1, "ovr_pend");
        step(); clr_req();
        step();
        bus.stall = 1'b0;
        exp_at(1, F_PC0, 32'h7000, "ovr_pc0");
        exp_at(1, F_FLUSH, 1, "ovr_flush");
        nred++;
        step(2);

        // New request at stall release beats the latched one.
        bus.stall = 1'b1;
        step();
        bus.branch_req = 1'b1; bus.branch_pc = 32'h9000;
        step(); clr_req();
        bus.stall = 1'b0;
        bus.jump_req = 1'b1; bus.jump_pc = 32'hA000;
        exp_at(0, F_SRC, 3, "race_src");
        exp_at(1, F_PC0, 32'hA000, "race_pc0");
        exp_at(1, F_FLUSH, 1, "race_flush");
        exp_at(2, F_FV, 1, "race_fv");
        exp_at(2, F_PC0, 32'hA000, "race_pc0_run");
        nred++;
        step(); clr_req();
        step();

        // Redirect again while in BUBBLE; misaligned target is word aligned.
        bus.branch_req = 1'b1; bus.branch_pc = 32'hB002;
        exp_at(1, F_PC0, 32'hB000, "bub_pc0_a");
        exp_at(1, F_FLUSH, 1, "bub_flush_a");
        nred++;
        step(); clr_req();
        bus.jump_req = 1'b1; bus.jump_pc = 32'hC000;
        exp_at(1, F_PC0, 32'hC000, "bub_pc0_b");
        exp_at(1, F_FLUSH, 1, "bub_flush_b");
        exp_at(1, F_FV, 0, "bub_fv_b");
        exp_at(2, F_FV, 1, "bub_fv_run");
        exp_at(2, F_PC0, 32'hC000, "bub_pc0_run");
        exp_at(2, F_FLUSH, 0, "bub_flush_run");
        nred++;
        step(); clr_req();
        step();

        // Address wrap at the top of the space.
        bus.jump_req = 1'b1; bus.jump_pc = 32'hFFFF_FFF8;
        exp_at(2, F_PC0, 32'hFFFF_FFF8, "wrap_pc0");
        exp_at(2, F_PC1, 32'hFFFF_FFFC, "wrap_pc1");
        exp_at(3, F_PC0, 32'h0000_0000, "wrap_pc0_next");
        exp_at(3, F_PC1, 32'h0000_0004, "wrap_pc1_next");
        nred++;
        step(); clr_req();
        step(2);
        exp_at(0, F_CNT, exp_cnt(nred), "cnt_b");

        // Reset while a redirect is pending: discarded, no flush afterwards.
        bus.stall = 1'b1;
        step();
        bus.jalr_req = 1'b1; bus.jalr_pc = 32'hD000;
        step(); clr_req();
        exp_at(0, F_PEND, 1, "pre_rst_pend");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        bus.stall = 1'b0;
        step(2);
        rst_n = 1'b1;
        exp_at(0, F_FV, 0, "post_boot_fv");
        exp_at(1, F_FV, 1, "post_fv");
        exp_at(1, F_PC0, 32'h100, "post_pc0");
        exp_at(1, F_FLUSH, 0, "post_flush_a");
        exp_at(2, F_FLUSH, 0, "post_flush_b");
        exp_at(1, F_PEND, 0, "post_pend");
        exp_at(2, F_PC0, 32'h108, "post_pc0_b");
        step(4);

        foreach (sb[i]) begin
            checks++;
            $display("FAIL %s: expectation left unchecked", sb[i].name);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
